// File: rtl/versatile_io_wb_hub_pkg.sv
// Shared types and helpers for the versatile I/O Wishbone hub: FSM encoding,
// local register offsets, STATUS bit positions and byte-lane steering.
package versatile_io_wb_hub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CH_WAIT = 2'd1,
        ST_RESP    = 2'd2,
        ST_ERR     = 2'd3
    } hub_state_e;

    localparam logic [2:0] OFF_PEND   = 3'd0;
    localparam logic [2:0] OFF_MASK   = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;

    localparam int STAT_TIMEOUT_BIT = 0;
    localparam int STAT_DECERR_BIT  = 1;

    function automatic logic sel_onehot(input logic [3:0] sel);
        return (sel == 4'b0001) || (sel == 4'b0010) ||
               (sel == 4'b0100) || (sel == 4'b1000);
    endfunction

    // Only meaningful for a one-hot sel; anything else is rejected before use.
    function automatic logic [7:0] steer_byte(input logic [31:0] dat, input logic [3:0] sel);
        logic [7:0] b;
        case (sel)
            4'b0001: b = dat[7:0];
            4'b0010: b = dat[15:8];
            4'b0100: b = dat[23:16];
            4'b1000: b = dat[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/versatile_io_irq_ctrl.sv
// Interrupt aggregator: rising-edge capture into sticky PEND bits (set beats
// same-cycle write-1-to-clear), a MASK register and a registered irq output.
module versatile_io_irq_ctrl #(
    parameter int NCH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] ch_irq_i,
    input  logic [NCH-1:0] pend_clr_i,
    input  logic           mask_we_i,
    input  logic [NCH-1:0] mask_dat_i,
    output logic [NCH-1:0] pend_o,
    output logic [NCH-1:0] mask_o,
    output logic           irq_o
);

    logic [NCH-1:0] irq_d_r;
    logic [NCH-1:0] pend_r;
    logic [NCH-1:0] mask_r;
    logic           irq_r;

    // Edge detect, pending/mask registers and aggregated interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_d_r <= {NCH{1'b0}};
            pend_r  <= {NCH{1'b0}};
            mask_r  <= {NCH{1'b0}};
            irq_r   <= 1'b0;
        end else begin
            irq_d_r <= ch_irq_i;
            pend_r  <= (pend_r & ~pend_clr_i) | (ch_irq_i & ~irq_d_r);
            if (mask_we_i) begin
                mask_r <= mask_dat_i;
            end else begin
                mask_r <= mask_r;
            end
            irq_r   <= |(pend_r & mask_r);
        end
    end

    assign pend_o = pend_r;
    assign mask_o = mask_r;
    assign irq_o  = irq_r;

endmodule

// File: rtl/versatile_io_wb_hub.sv
// Wishbone B4 pipelined slave hub: decodes byte-wide peripheral channels plus a
// local register block, with registered responses, timeout and IRQ aggregation.
module versatile_io_wb_hub
    import versatile_io_wb_hub_pkg::*;
#(
    parameter int          NCH      = 4,
    parameter int          CS_HI    = 31,
    parameter int          CS_LO    = 8,
    parameter logic [31:0] BASE_ADR = 32'h9000_0000,
    parameter int          IDX_HI   = 5,
    parameter int          IDX_LO   = 3,
    parameter int          TIMEOUT  = 15
) (
    input  logic             wbs_clk,
    input  logic             wbs_rst,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic             wbs_we_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    output logic [31:0]      wbs_dat_o,
    output logic             wbs_ack_o,
    output logic             wbs_err_o,
    output logic             wbs_stall_o,
    output logic [NCH-1:0]   ch_cyc_o,
    output logic [NCH-1:0]   ch_stb_o,
    output logic             ch_we_o,
    output logic [2:0]       ch_adr_o,
    output logic [7:0]       ch_dat_o,
    input  logic [8*NCH-1:0] ch_dat_i,
    input  logic [NCH-1:0]   ch_ack_i,
    input  logic [NCH-1:0]   ch_irq_i,
    output logic             irq_o
);

    hub_state_e     state_r, state_n;
    logic [2:0]     idx_r, off_r;
    logic           we_r;
    logic [7:0]     wr_byte_r;
    logic [7:0]     cnt_r, cnt_n;
    logic [1:0]     status_r;
    logic [NCH-1:0] stb_r, stb_n;
    logic           ack_r, err_r, stall_r;
    logic [31:0]    dat_r, dat_n;

    logic           acc_s, dec_err_s, loc_s;
    logic [2:0]     in_idx_s;
    logic [7:0]     in_byte_s, loc_rd_s, sel_byte_s;
    logic [NCH-1:0] in_hot_s;
    logic           sel_ack_s;
    logic           set_to_s, set_de_s, loc_wr_s;
    logic [1:0]     status_clr_s, status_set_s;
    logic [NCH-1:0] pend_s, mask_s, pend_clr_s;
    logic           adr_unused_s;

    assign in_idx_s  = wbs_adr_i[IDX_HI:IDX_LO];
    assign in_byte_s = steer_byte(wbs_dat_i, wbs_sel_i);
    assign acc_s     = (state_r == ST_IDLE) && wbs_cyc_i && wbs_stb_i &&
                       (wbs_adr_i[CS_HI:CS_LO] == BASE_ADR[CS_HI:CS_LO]);
    assign dec_err_s = !sel_onehot(wbs_sel_i) || (in_idx_s > 3'(NCH));
    assign loc_s     = (in_idx_s == 3'(NCH));
    assign adr_unused_s = ^wbs_adr_i;

    // Channel decode of the incoming index and mux of the latched channel's ack/data
    always_comb begin
        sel_ack_s  = 1'b0;
        sel_byte_s = 8'h00;
        in_hot_s   = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            in_hot_s[i] = (in_idx_s == 3'(i));
            sel_ack_s   = sel_ack_s | (ch_ack_i[i] & (idx_r == 3'(i)));
            sel_byte_s  = sel_byte_s | (ch_dat_i[8*i +: 8] & {8{idx_r == 3'(i)}});
        end
    end

    // Local register read mux; unmapped offsets read as zero
    always_comb begin
        loc_rd_s = 8'h00;
        case (wbs_adr_i[2:0])
            OFF_PEND:   loc_rd_s = 8'(pend_s);
            OFF_MASK:   loc_rd_s = 8'(mask_s);
            OFF_STATUS: loc_rd_s = 8'(status_r);
            default:    loc_rd_s = 8'h00;
        endcase
    end

    // Next-state logic; response data and status events are decided here
    always_comb begin
        state_n  = state_r;
        stb_n    = stb_r;
        cnt_n    = cnt_r;
        dat_n    = 32'h0000_0000;
        set_to_s = 1'b0;
        set_de_s = 1'b0;
        loc_wr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stb_n = {NCH{1'b0}};
                cnt_n = 8'h00;
                if (acc_s && dec_err_s) begin
                    state_n  = ST_ERR;
                    set_de_s = 1'b1;
                end else if (acc_s && loc_s) begin
                    state_n  = ST_RESP;
                    loc_wr_s = wbs_we_i;
                    dat_n    = wbs_we_i ? 32'h0000_0000 : {4{loc_rd_s}};
                end else if (acc_s) begin
                    state_n = ST_CH_WAIT;
                    stb_n   = in_hot_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CH_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_n = ST_IDLE;
                    stb_n   = {NCH{1'b0}};
                end else if (sel_ack_s) begin
                    state_n = ST_RESP;
                    stb_n   = {NCH{1'b0}};
                    dat_n   = we_r ? 32'h0000_0000 : {4{sel_byte_s}};
                end else if (cnt_r == 8'(TIMEOUT - 1)) begin
                    state_n  = ST_ERR;
                    stb_n    = {NCH{1'b0}};
                    set_to_s = 1'b1;
                end else begin
                    cnt_n = cnt_r + 8'd1;
                end
            end
            ST_RESP, ST_ERR: begin
                state_n = ST_IDLE;
                stb_n   = {NCH{1'b0}};
            end
            default: begin
                state_n = ST_IDLE;
                stb_n   = {NCH{1'b0}};
            end
        endcase
    end

    // STATUS sticky-set / write-1-to-clear terms
    always_comb begin
        status_set_s                   = 2'b00;
        status_set_s[STAT_TIMEOUT_BIT] = set_to_s;
        status_set_s[STAT_DECERR_BIT]  = set_de_s;
        status_clr_s = (loc_wr_s && (wbs_adr_i[2:0] == OFF_STATUS)) ? in_byte_s[1:0] : 2'b00;
    end

    assign pend_clr_s = (loc_wr_s && (wbs_adr_i[2:0] == OFF_PEND)) ? in_byte_s[NCH-1:0] : {NCH{1'b0}};

    // State, request latch, status and registered bus outputs
    always_ff @(posedge wbs_clk) begin
        if (wbs_rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= 3'd0;
            off_r     <= 3'd0;
            we_r      <= 1'b0;
            wr_byte_r <= 8'h00;
            cnt_r     <= 8'h00;
            status_r  <= 2'b00;
            stb_r     <= {NCH{1'b0}};
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
            stall_r   <= 1'b0;
            dat_r     <= 32'h0000_0000;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            stb_r    <= stb_n;
            status_r <= (status_r & ~status_clr_s) | status_set_s;
            ack_r    <= (state_n == ST_RESP);
            err_r    <= (state_n == ST_ERR);
            stall_r  <= (state_n != ST_IDLE);
            dat_r    <= dat_n;
            if (acc_s) begin
                idx_r     <= in_idx_s;
                off_r     <= wbs_adr_i[2:0];
                we_r      <= wbs_we_i;
                wr_byte_r <= in_byte_s;
            end else begin
                idx_r     <= idx_r;
                off_r     <= off_r;
                we_r      <= we_r;
                wr_byte_r <= wr_byte_r;
            end
        end
    end

    versatile_io_irq_ctrl #(.NCH(NCH)) u_irq (
        .clk        (wbs_clk),
        .rst        (wbs_rst),
        .ch_irq_i   (ch_irq_i),
        .pend_clr_i (pend_clr_s),
        .mask_we_i  (loc_wr_s && (wbs_adr_i[2:0] == OFF_MASK)),
        .mask_dat_i (in_byte_s[NCH-1:0]),
        .pend_o     (pend_s),
        .mask_o     (mask_s),
        .irq_o      (irq_o)
    );

    assign wbs_dat_o   = dat_r;
    assign wbs_ack_o   = ack_r;
    assign wbs_err_o   = err_r;
    assign wbs_stall_o = stall_r;
    assign ch_cyc_o    = stb_r;
    assign ch_stb_o    = stb_r;
    assign ch_we_o     = we_r;
    assign ch_adr_o    = off_r;
    assign ch_dat_o    = wr_byte_r;

endmodule

// File: tb/tb_versatile_io_wb_hub.sv
// Directed self-checking bench for versatile_io_wb_hub: expected responses are
// queued when each access is issued and compared when the hub terminates it.
module tb_versatile_io_wb_hub;

    localparam int NCH = 4;
    localparam logic [31:0] BASE = 32'h9000_0000;

    logic             wbs_clk, wbs_rst;
    logic [31:0]      wbs_dat_i, wbs_adr_i;
    logic [3:0]       wbs_sel_i;
    logic             wbs_we_i, wbs_stb_i, wbs_cyc_i;
    logic [31:0]      wbs_dat_o;
    logic             wbs_ack_o, wbs_err_o, wbs_stall_o;
    logic [NCH-1:0]   ch_cyc_o, ch_stb_o;
    logic             ch_we_o;
    logic [2:0]       ch_adr_o;
    logic [7:0]       ch_dat_o;
    logic [8*NCH-1:0] ch_dat_i;
    logic [NCH-1:0]   ch_ack_i, ch_irq_i;
    logic             irq_o;

    typedef struct {
        string       tag;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_nstb;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_errors = 0;

    versatile_io_wb_hub #(.NCH(NCH), .TIMEOUT(15)) dut (
        .wbs_clk(wbs_clk), .wbs_rst(wbs_rst), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .wbs_stall_o(wbs_stall_o), .ch_cyc_o(ch_cyc_o), .ch_stb_o(ch_stb_o), .ch_we_o(ch_we_o),
        .ch_adr_o(ch_adr_o), .ch_dat_o(ch_dat_o), .ch_dat_i(ch_dat_i), .ch_ack_i(ch_ack_i),
        .ch_irq_i(ch_irq_i), .irq_o(irq_o)
    );

    initial wbs_clk = 1'b0;
    always #5 wbs_clk = ~wbs_clk;

    task automatic step();
        @(posedge wbs_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_adr(input logic [2:0] idx, input logic [2:0] off);
        return BASE | {26'd0, idx, off};
    endfunction

    // One access: issue, model a channel that acks after ack_after strobe cycles (-1: never).
    task automatic do_txn(input string tag, input logic [2:0] idx, input logic [2:0] off,
                          input logic we, input logic [3:0] sel, input logic [31:0] dat,
                          input int ack_after, input logic exp_err, input logic [31:0] exp_dat,
                          input logic [3:0] exp_stb, input int exp_nstb, input logic [7:0] exp_chdat);
        exp_t e, got;
        int   nstb;
        bit   done;
        e.tag = tag; e.exp_err = exp_err; e.exp_dat = exp_dat; e.exp_nstb = exp_nstb;
        sb_q.push_back(e);
        wbs_adr_i = mk_adr(idx, off);
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_dat_i = dat;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        step();
        wbs_stb_i = 1'b0;
        chk({tag, "/stall"}, 32'(wbs_stall_o), 32'd1);
        chk({tag, "/stb"}, 32'(ch_stb_o), 32'(exp_stb));
        chk({tag, "/cyc"}, 32'(ch_cyc_o), 32'(exp_stb));
        if (exp_stb != 4'b0000) begin
            chk({tag, "/ch_adr"}, 32'(ch_adr_o), 32'(off));
            chk({tag, "/ch_we"}, 32'(ch_we_o), 32'(we));
            if (we) chk({tag, "/ch_dat"}, 32'(ch_dat_o), 32'(exp_chdat));
        end
        nstb = 0;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            ch_ack_i = 4'b0000;
            if (wbs_ack_o || wbs_err_o) begin
                got = sb_q.pop_front();
                chk({got.tag, "/err"}, 32'(wbs_err_o), 32'(got.exp_err));
                chk({got.tag, "/ack"}, 32'(wbs_ack_o), 32'(!got.exp_err));
                chk({got.tag, "/dat"}, wbs_dat_o, got.exp_dat);
                chk({got.tag, "/nstb"}, 32'(nstb), 32'(got.exp_nstb));
                chk({got.tag, "/stb_off"}, 32'(ch_stb_o), 32'd0);
                done = 1'b1;
            end else begin
                if (ch_stb_o != 4'b0000) nstb++;
                if (ack_after >= 0 && nstb == ack_after) ch_ack_i = 4'b0001 << idx;
            end
            step();
        end
        chk({tag, "/terminated"}, 32'(done), 32'd1);
        if (!done && sb_q.size() > 0) got = sb_q.pop_front();
        chk({tag, "/one_cycle"}, {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
        chk({tag, "/idle_stall"}, 32'(wbs_stall_o), 32'd0);
        wbs_cyc_i = 1'b0;
        ch_ack_i  = 4'b0000;
    endtask

    initial begin
        bit any_term;
        wbs_rst = 1'b1; wbs_dat_i = 32'h0; wbs_adr_i = 32'h0; wbs_sel_i = 4'h0;
        wbs_we_i = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        ch_dat_i = 32'h445A_2211; ch_ack_i = 4'h0; ch_irq_i = 4'h0;
        step(); step(); step();
        wbs_rst = 1'b0;
        step();
        chk("rst/ack", 32'(wbs_ack_o), 32'd0);
        chk("rst/err", 32'(wbs_err_o), 32'd0);
        chk("rst/stall", 32'(wbs_stall_o), 32'd0);
        chk("rst/stb", 32'(ch_stb_o), 32'd0);
        chk("rst/dat", wbs_dat_o, 32'd0);
        chk("rst/irq", 32'(irq_o), 32'd0);

        do_txn("wr_ch1", 3'd1, 3'd3, 1'b1, 4'b0010, 32'h0000_AB00, 3, 1'b0, 32'h0, 4'b0010, 3, 8'hAB);
        do_txn("rd_ch2", 3'd2, 3'd0, 1'b0, 4'b0001, 32'h0, 2, 1'b0, 32'h5A5A_5A5A, 4'b0100, 2, 8'h00);
        do_txn("to_ch0", 3'd0, 3'd0, 1'b0, 4'b0001, 32'h0, -1, 1'b1, 32'h0, 4'b0001, 15, 8'h00);
        do_txn("rd_stat_to", 3'd4, 3'd2, 1'b0, 4'b0001, 32'h0, -1, 1'b0, 32'h0101_0101, 4'b0000, 0, 8'h00);
        do_txn("clr_stat", 3'd4, 3'd2, 1'b1, 4'b0001, 32'h0000_0001, -1, 1'b0, 32'h0, 4'b0000, 0, 8'h00);
        do_txn("rd_stat_0", 3'd4, 3'd2, 1'b0, 4'b0001, 32'h0, -1, 1'b0, 32'h0, 4'b0000, 0, 8'h00);
        do_txn("bad_sel", 3'd0, 3'd0, 1'b0, 4'b0011, 32'h0, -1, 1'b1, 32'h0, 4'b0000, 0, 8'h00);
        do_txn("rd_stat_de", 3'd4, 3'd2, 1'b0, 4'b0001, 32'h0, -1, 1'b0, 32'h0202_0202, 4'b0000, 0, 8'h00);
        do_txn("clr_stat2", 3'd4, 3'd2, 1'b1, 4'b0100, 32'h0002_0000, -1, 1'b0, 32'h0, 4'b0000, 0, 8'h00);
        do_txn("bad_idx", 3'd6, 3'd0, 1'b0, 4'b0001, 32'h0, -1, 1'b1, 32'h0, 4'b0000, 0, 8'h00);
        do_txn("rd_stat_de2", 3'd4, 3'd2, 1'b0, 4'b0001, 32'h0, -1, 1'b0, 32'h0202_0202, 4'b0000, 0, 8'h00);
        do_txn("rd_off5", 3'd4, 3'd5, 1'b0, 4'b0001, 32'h0, -1, 1'b0, 32'h0, 4'b0000, 0, 8'h00);

        // IRQ: mask channel 1, pulse it, then clear with a coincident fresh edge
        do_txn("wr_mask", 3'd4, 3'd1, 1'b1, 4'b1000, 32'h0200_0000, -1, 1'b0, 32'h0, 4'b0000, 0, 8'h00);
        do_txn("rd_mask", 3'd4, 3'd1, 1'b0, 4'b0001, 32'h0, -1, 1'b0, 32'h0202_0202, 4'b0000, 0, 8'h00);
        ch_irq_i = 4'b0010; step(); ch_irq_i = 4'b0000; step(); step();
        chk("irq1/irq_o", 32'(irq_o), 32'd1);
        do_txn("rd_pend1", 3'd4, 3'd0, 1'b0, 4'b0001, 32'h0, -1, 1'b0, 32'h0202_0202, 4'b0000, 0, 8'h00);
        ch_irq_i = 4'b0010;
        do_txn("w1c_vs_set", 3'd4, 3'd0, 1'b1, 4'b0001, 32'h0000_0002, -1, 1'b0, 32'h0, 4'b0000, 0, 8'h00);
        do_txn("rd_pend_kept", 3'd4, 3'd0, 1'b0, 4'b0001, 32'h0, -1, 1'b0, 32'h0202_0202, 4'b0000, 0, 8'h00);
        chk("irq_kept", 32'(irq_o), 32'd1);
        ch_irq_i = 4'b0000;
        do_txn("w1c_pend", 3'd4, 3'd0, 1'b1, 4'b0001, 32'h0000_0002, -1, 1'b0, 32'h0, 4'b0000, 0, 8'h00);
        do_txn("rd_pend_clr", 3'd4, 3'd0, 1'b0, 4'b0001, 32'h0, -1, 1'b0, 32'h0, 4'b0000, 0, 8'h00);
        chk("irq_cleared", 32'(irq_o), 32'd0);
        ch_irq_i = 4'b0001; step(); ch_irq_i = 4'b0000; step(); step(); step();
        chk("irq_masked", 32'(irq_o), 32'd0);
        do_txn("rd_pend0", 3'd4, 3'd0, 1'b0, 4'b0001, 32'h0, -1, 1'b0, 32'h0101_0101, 4'b0000, 0, 8'h00);

        // Address outside the hub window is ignored
        wbs_adr_i = 32'h8000_0020; wbs_sel_i = 4'b0001; wbs_we_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        step();
        wbs_stb_i = 1'b0;
        chk("no_cs/stall", 32'(wbs_stall_o), 32'd0);
        chk("no_cs/stb", 32'(ch_stb_o), 32'd0);
        step();
        chk("no_cs/term", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
        wbs_cyc_i = 1'b0;

        // Abort: drop cyc in the second strobe cycle
        wbs_adr_i = mk_adr(3'd3, 3'd0); wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        step();
        wbs_stb_i = 1'b0;
        chk("abort/stb", 32'(ch_stb_o), 32'h8);
        step();
        wbs_cyc_i = 1'b0;
        step();
        chk("abort/stb_drop", 32'(ch_stb_o), 32'd0);
        chk("abort/term", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
        step();
        chk("abort/term2", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
        chk("abort/stall", 32'(wbs_stall_o), 32'd0);
        do_txn("after_abort", 3'd3, 3'd0, 1'b0, 4'b0001, 32'h0, 1, 1'b0, 32'h4444_4444, 4'b1000, 1, 8'h00);

        // Reset in the middle of a channel wait
        wbs_adr_i = mk_adr(3'd0, 3'd1); wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        step();
        wbs_stb_i = 1'b0;
        step();
        wbs_rst = 1'b1;
        step();
        wbs_rst = 1'b0;
        wbs_cyc_i = 1'b0;
        chk("mid_rst/stb", 32'(ch_stb_o), 32'd0);
        chk("mid_rst/stall", 32'(wbs_stall_o), 32'd0);
        any_term = 1'b0;
        for (int i = 0; i < 20; i++) begin
            any_term = any_term | wbs_ack_o | wbs_err_o;
            step();
        end
        chk("mid_rst/no_term", 32'(any_term), 32'd0);
        do_txn("rd_mask_rst", 3'd4, 3'd1, 1'b0, 4'b0001, 32'h0, -1, 1'b0, 32'h0, 4'b0000, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
